// File: rtl/imu_sample_scheduler.sv
// imu_sample_scheduler: once per sample period, polls NUM_CH sources in order and streams tagged samples.
// Define IMU_SCHED_OVERRUN_CNT_EN to add the saturating overrun counter (otherwise overrun_cnt is 0).

module imu_sample_scheduler #(
  parameter int WIDTH   = 16,
  parameter int NUM_CH  = 3,
  parameter int CH_W    = 2,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    frame_done,
  output logic                    err_pulse,
  output logic [CH_W-1:0]         err_ch,
  output logic                    overrun,
  output logic [7:0]              overrun_cnt
);

  localparam int PCNT_W = $clog2(PERIOD);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PERIOD - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

  state_t            state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;
  logic              overrun_q, overrun_d;
  logic              tick, advance, sel_valid, is_last;
  logic [WIDTH-1:0]  sel_data;

  always_comb begin
    tick   = enable && (pcnt_q == PCNT_MAX);
    pcnt_d = '0;
    if (enable) begin
      pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
    end
  end

  // Only the currently polled channel's valid/data is ever looked at.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    ch_req    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_valid = ch_valid[i];
        sel_data  = ch_data[i*WIDTH +: WIDTH];
        ch_req[i] = (state_q == REQ);
      end
    end
    is_last = (ch_q == LAST_CH);
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    ch_d         = ch_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_ch_d     = err_ch_q;
    overrun_d    = tick && (state_q != IDLE);
    advance      = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          ch_d    = '0;
          wcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sel_valid) begin
          out_data_d = sel_data;
          out_ch_d   = ch_q;
          out_last_d = is_last;
          wcnt_d     = '0;
          state_d    = OUT;
        end else if (wcnt_q == WCNT_MAX) begin
          err_pulse_d = 1'b1;
          err_ch_d    = ch_q;
          advance     = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared by the timeout path and the output handshake.
    if (advance) begin
      wcnt_d = '0;
      if (is_last) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      wcnt_q       <= '0;
      ch_q         <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_ch_q     <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      wcnt_q       <= wcnt_d;
      ch_q         <= ch_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      err_pulse_q  <= err_pulse_d;
      err_ch_q     <= err_ch_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef IMU_SCHED_OVERRUN_CNT_EN
  logic [7:0] ocnt_q, ocnt_d;

  always_comb begin
    ocnt_d = ocnt_q;
    if (overrun_d && (ocnt_q != 8'hFF)) begin
      ocnt_d = ocnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ocnt_q <= '0;
    end else begin
      ocnt_q <= ocnt_d;
    end
  end

  assign overrun_cnt = ocnt_q;
`else
  assign overrun_cnt = '0;
`endif

  assign out_valid  = (state_q == OUT);
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign err_pulse  = err_pulse_q;
  assign err_ch     = err_ch_q;
  assign overrun    = overrun_q;

endmodule
